// File: rtl/reg_file_if.sv
// Register file bundle: issue/commit/flush from the ROB, decoder read ports and ROB tag queries.
// The reg_file side uses the slave modport; the pipeline side uses master.
interface reg_file_if #(
    parameter int unsigned ROB_BIT = 4
);
    logic               clear_up;
    logic               issue_pollute;
    logic [4:0]         issue_reg_id;
    logic [ROB_BIT-1:0] issue_rob_entry;
    logic               rob_commit;
    logic [4:0]         commit_rd_reg_id;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic [31:0]        commit_value;
    logic [4:0]         rs1_id;
    logic [4:0]         rs2_id;
    logic               rs1_ready;
    logic               rs2_ready;
    logic [31:0]        rs1_value;
    logic [31:0]        rs2_value;
    logic [ROB_BIT-1:0] rs1_rob_entry;
    logic [ROB_BIT-1:0] rs2_rob_entry;
    logic [ROB_BIT-1:0] get_rob_entry1;
    logic [ROB_BIT-1:0] get_rob_entry2;
    logic               ready1;
    logic               ready2;
    logic [31:0]        value1;
    logic [31:0]        value2;

    modport master (
        output clear_up, issue_pollute, issue_reg_id, issue_rob_entry,
        output rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
        output rs1_id, rs2_id, ready1, ready2, value1, value2,
        input  rs1_ready, rs2_ready, rs1_value, rs2_value,
        input  rs1_rob_entry, rs2_rob_entry, get_rob_entry1, get_rob_entry2
    );

    modport slave (
        input  clear_up, issue_pollute, issue_reg_id, issue_rob_entry,
        input  rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
        input  rs1_id, rs2_id, ready1, ready2, value1, value2,
        output rs1_ready, rs2_ready, rs1_value, rs2_value,
        output rs1_rob_entry, rs2_rob_entry, get_rob_entry1, get_rob_entry2
    );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with busy/ROB-tag renaming and two combinational read ports.
// Define REG_COMMIT_BYPASS_EN to forward a same-cycle commit onto a busy operand read.
module reg_file #(
    parameter int unsigned ROB_BIT = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    reg_file_if.slave  bus
);
    localparam int unsigned NREG = 32;
    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0]    regs [NREG];
    logic [NREG-1:0]    busy;
    logic [ROB_BIT-1:0] tag  [NREG];

    logic commit_en;
    logic issue_en;
    logic hit1_c;
    logic hit2_c;

    assign commit_en = rdy_in && bus.rob_commit && (bus.commit_rd_reg_id != 5'd0);
    assign issue_en  = rdy_in && bus.issue_pollute && !bus.clear_up && (bus.issue_reg_id != 5'd0);

    // Issue is applied after commit so a same-register claim keeps busy set with the new tag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            if (commit_en) begin
                regs[bus.commit_rd_reg_id] <= bus.commit_value;
                if (tag[bus.commit_rd_reg_id] == bus.commit_rob_entry)
                    busy[bus.commit_rd_reg_id] <= 1'b0;
            end
            if (bus.clear_up) begin
                busy <= '0;
                for (int unsigned i = 0; i < NREG; i++)
                    tag[i] <= '0;
            end else if (issue_en) begin
                busy[bus.issue_reg_id] <= 1'b1;
                tag[bus.issue_reg_id]  <= bus.issue_rob_entry;
            end
        end
    end

`ifdef REG_COMMIT_BYPASS_EN
    assign hit1_c = bus.rob_commit && (bus.commit_rd_reg_id == bus.rs1_id)
                    && (tag[bus.rs1_id] == bus.commit_rob_entry);
    assign hit2_c = bus.rob_commit && (bus.commit_rd_reg_id == bus.rs2_id)
                    && (tag[bus.rs2_id] == bus.commit_rob_entry);
`else
    assign hit1_c = 1'b0;
    assign hit2_c = 1'b0;
`endif

    assign bus.get_rob_entry1 = tag[bus.rs1_id];
    assign bus.get_rob_entry2 = tag[bus.rs2_id];
    assign bus.rs1_rob_entry  = tag[bus.rs1_id];
    assign bus.rs2_rob_entry  = tag[bus.rs2_id];

    // Operand resolution from pre-edge state: x0, clean register, commit bypass, then ROB.
    always_comb begin
        bus.rs1_ready = 1'b1;
        bus.rs1_value = '0;
        if (bus.rs1_id != 5'd0) begin
            if (!busy[bus.rs1_id]) begin
                bus.rs1_value = regs[bus.rs1_id];
            end else if (hit1_c) begin
                bus.rs1_value = bus.commit_value;
            end else begin
                bus.rs1_ready = bus.ready1;
                bus.rs1_value = bus.value1;
            end
        end
    end

    always_comb begin
        bus.rs2_ready = 1'b1;
        bus.rs2_value = '0;
        if (bus.rs2_id != 5'd0) begin
            if (!busy[bus.rs2_id]) begin
                bus.rs2_value = regs[bus.rs2_id];
            end else if (hit2_c) begin
                bus.rs2_value = bus.commit_value;
            end else begin
                bus.rs2_ready = bus.ready2;
                bus.rs2_value = bus.value2;
            end
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file;
    localparam int unsigned RB = 4;

`ifdef REG_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    always #5 clk_in = ~clk_in;

    reg_file_if #(.ROB_BIT(RB)) bus ();
    reg_file #(.ROB_BIT(RB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]   m_reg  [32];
    logic          m_busy [32];
    logic [RB-1:0] m_tag  [32];

    // Reference behaviour of one clock edge, from the register-renaming rules.
    task automatic model_step();
        logic issue_ok;
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'h0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy_in) begin
            issue_ok = bus.issue_pollute && !bus.clear_up && (bus.issue_reg_id != 5'd0);
            if (bus.rob_commit && bus.commit_rd_reg_id != 5'd0) begin
                m_reg[bus.commit_rd_reg_id] = bus.commit_value;
                if (m_tag[bus.commit_rd_reg_id] == bus.commit_rob_entry
                    && !(issue_ok && bus.issue_reg_id == bus.commit_rd_reg_id))
                    m_busy[bus.commit_rd_reg_id] = 1'b0;
            end
            if (bus.clear_up) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0; m_tag[i] = '0;
                end
            end else if (issue_ok) begin
                m_busy[bus.issue_reg_id] = 1'b1;
                m_tag[bus.issue_reg_id]  = bus.issue_rob_entry;
            end
        end
    endtask

    function automatic logic [32:0] exp_read(input logic [4:0] id, input logic rn, input logic [31:0] vn);
        if (id == 5'd0)         return {1'b1, 32'h0};
        if (!m_busy[id])        return {1'b1, m_reg[id]};
        if (BYP && bus.rob_commit && bus.commit_rd_reg_id == id && m_tag[id] == bus.commit_rob_entry)
            return {1'b1, bus.commit_value};
        return {rn, vn};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1;
        bus.clear_up = 1'b0; bus.issue_pollute = 1'b0; bus.issue_reg_id = 5'd0; bus.issue_rob_entry = '0;
        bus.rob_commit = 1'b0; bus.commit_rd_reg_id = 5'd0; bus.commit_rob_entry = '0; bus.commit_value = 32'h0;
        bus.rs1_id = 5'd0; bus.rs2_id = 5'd0; bus.ready1 = 1'b0; bus.ready2 = 1'b0;
        bus.value1 = 32'h0; bus.value2 = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1; rdy_in = 1'b0;
        bus.issue_pollute = 1'b1; bus.issue_reg_id = 5'd5; bus.issue_rob_entry = 4'd9;
        bus.rob_commit = 1'b1; bus.commit_rd_reg_id = 5'd5; bus.commit_value = 32'hFFFF_0000;
        tick();
        idle();
        for (int r = 1; r < 32; r += 6) begin
            bus.rs1_id = 5'(r); bus.rs2_id = 5'(r + 1); bus.value1 = 32'hDEAD; bus.value2 = 32'hBEEF;
            #1;
            n_cmp++;
            if ({bus.rs1_ready, bus.rs1_value, bus.rs1_rob_entry, bus.get_rob_entry1} !== {1'b1, 32'h0, 4'h0, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_rs1 x%0d: got rdy=%b val=%h tag=%h get=%h, want 1/0/0/0", r,
                         bus.rs1_ready, bus.rs1_value, bus.rs1_rob_entry, bus.get_rob_entry1);
            end
            n_cmp++;
            if ({bus.rs2_ready, bus.rs2_value, bus.rs2_rob_entry, bus.get_rob_entry2} !== {1'b1, 32'h0, 4'h0, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_rs2 x%0d: got rdy=%b val=%h tag=%h get=%h, want 1/0/0/0", r + 1,
                         bus.rs2_ready, bus.rs2_value, bus.rs2_rob_entry, bus.get_rob_entry2);
            end
        end
    endtask

    task automatic test_issue_query();
        idle();
        bus.issue_pollute = 1'b1; bus.issue_reg_id = 5'd5; bus.issue_rob_entry = 4'd3;
        tick();
        idle();
        bus.rs1_id = 5'd5; bus.ready1 = 1'b0; bus.value1 = 32'hDEAD;
        #1;
        n_cmp++;
        if ({bus.rs1_ready, bus.get_rob_entry1, bus.rs1_rob_entry} !== {1'b0, 4'd3, 4'd3}) begin
            n_fail++;
            $display("FAIL issue_pending: got rdy=%b get=%h tag=%h, want 0/3/3", bus.rs1_ready, bus.get_rob_entry1, bus.rs1_rob_entry);
        end
        bus.ready1 = 1'b1; bus.value1 = 32'h1234;
        #1;
        n_cmp++;
        if ({bus.rs1_ready, bus.rs1_value} !== {1'b1, 32'h1234}) begin
            n_fail++;
            $display("FAIL issue_rob_value: got rdy=%b val=%h, want 1/00001234", bus.rs1_ready, bus.rs1_value);
        end
        bus.clear_up = 1'b1;
        tick();
    endtask

    task automatic test_double_issue();
        idle();
        bus.issue_pollute = 1'b1; bus.issue_reg_id = 5'd5; bus.issue_rob_entry = 4'd3;
        tick();
        bus.issue_rob_entry = 4'd7;
        tick();
        idle();
        bus.rob_commit = 1'b1; bus.commit_rd_reg_id = 5'd5; bus.commit_rob_entry = 4'd3; bus.commit_value = 32'hAA;
        tick();
        idle();
        bus.rs1_id = 5'd5; bus.ready1 = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rs1_ready, bus.rs1_rob_entry} !== {1'b0, 4'd7}) begin
            n_fail++;
            $display("FAIL old_commit_keeps_claim: got rdy=%b tag=%h, want 0/7", bus.rs1_ready, bus.rs1_rob_entry);
        end
        bus.clear_up = 1'b1;
        tick();
        bus.clear_up = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rs1_ready, bus.rs1_value} !== {1'b1, 32'hAA}) begin
            n_fail++;
            $display("FAIL old_commit_data: got rdy=%b val=%h, want 1/000000aa", bus.rs1_ready, bus.rs1_value);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        bus.issue_pollute = 1'b1; bus.issue_reg_id = 5'd6; bus.issue_rob_entry = 4'd1;
        tick();
        bus.issue_rob_entry = 4'd2;
        bus.rob_commit = 1'b1; bus.commit_rd_reg_id = 5'd6; bus.commit_rob_entry = 4'd1; bus.commit_value = 32'h55;
        bus.rs1_id = 5'd6; bus.ready1 = 1'b0; bus.value1 = 32'h77;
        #1;
        n_cmp++;
        if ({bus.rs1_ready, bus.rs1_value, bus.rs1_rob_entry} !== (BYP ? {1'b1, 32'h55, 4'd1} : {1'b0, 32'h77, 4'd1})) begin
            n_fail++;
            $display("FAIL same_cycle_old_mapping: got rdy=%b val=%h tag=%h", bus.rs1_ready, bus.rs1_value, bus.rs1_rob_entry);
        end
        tick();
        idle();
        bus.rs2_id = 5'd6; bus.ready2 = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rs2_ready, bus.rs2_rob_entry} !== {1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL issue_beats_commit: got rdy=%b tag=%h, want 0/2", bus.rs2_ready, bus.rs2_rob_entry);
        end
        bus.clear_up = 1'b1;
        tick();
        bus.clear_up = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rs2_ready, bus.rs2_value} !== {1'b1, 32'h55}) begin
            n_fail++;
            $display("FAIL same_cycle_commit_data: got rdy=%b val=%h, want 1/00000055", bus.rs2_ready, bus.rs2_value);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.issue_pollute = 1'b1; bus.issue_reg_id = 5'd7; bus.issue_rob_entry = 4'd4;
        tick();
        idle();
        bus.rob_commit = 1'b1; bus.commit_rd_reg_id = 5'd7; bus.commit_rob_entry = 4'd4; bus.commit_value = 32'h99;
        bus.rs2_id = 5'd7; bus.ready2 = 1'b0; bus.value2 = 32'h1;
        #1;
        n_cmp++;
        if ({bus.rs2_ready, bus.rs2_value} !== (BYP ? {1'b1, 32'h99} : {1'b0, 32'h1})) begin
            n_fail++;
            $display("FAIL commit_bypass: got rdy=%b val=%h (bypass=%0d)", bus.rs2_ready, bus.rs2_value, BYP);
        end
        tick();
        idle();
        bus.rs2_id = 5'd7;
        #1;
        n_cmp++;
        if ({bus.rs2_ready, bus.rs2_value} !== {1'b1, 32'h99}) begin
            n_fail++;
            $display("FAIL commit_frees: got rdy=%b val=%h, want 1/00000099", bus.rs2_ready, bus.rs2_value);
        end
    endtask

    task automatic test_clear();
        idle();
        bus.issue_pollute = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            bus.issue_reg_id = 5'(r); bus.issue_rob_entry = 4'(r + 8);
            tick();
        end
        bus.clear_up = 1'b1; bus.issue_reg_id = 5'd4; bus.issue_rob_entry = 4'd5; rdy_in = 1'b0;
        tick();
        bus.rs1_id = 5'd2; bus.rs2_id = 5'd4; bus.ready1 = 1'b0; bus.ready2 = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rs1_ready, bus.rs1_rob_entry, bus.rs2_ready} !== {1'b0, 4'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_held_by_rdy: got rs1 rdy=%b tag=%h rs2 rdy=%b, want 0/a/1", bus.rs1_ready, bus.rs1_rob_entry, bus.rs2_ready);
        end
        rdy_in = 1'b1;
        tick();
        idle();
        for (int r = 1; r <= 4; r++) begin
            bus.rs1_id = 5'(r);
            #1;
            n_cmp++;
            if ({bus.rs1_ready, bus.rs1_rob_entry} !== {1'b1, 4'd0}) begin
                n_fail++;
                $display("FAIL clear_x%0d: got rdy=%b tag=%h, want 1/0", r, bus.rs1_ready, bus.rs1_rob_entry);
            end
        end
    endtask

    task automatic test_x0();
        idle();
        bus.issue_pollute = 1'b1; bus.issue_rob_entry = 4'd5;
        bus.rob_commit = 1'b1; bus.commit_value = 32'hFF; bus.commit_rob_entry = 4'd5;
        tick();
        idle();
        bus.ready1 = 1'b0; bus.value1 = 32'h3; bus.ready2 = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rs1_ready, bus.rs1_value, bus.get_rob_entry1, bus.rs2_ready, bus.rs2_value} !== {1'b1, 32'h0, 4'd0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL x0_hardwired: got rdy=%b val=%h get=%h rdy2=%b val2=%h", bus.rs1_ready, bus.rs1_value,
                     bus.get_rob_entry1, bus.rs2_ready, bus.rs2_value);
        end
    endtask

    task automatic test_random();
        logic [32:0]   e1, e2;
        logic [RB-1:0] t1, t2;
        for (int c = 0; c < 600; c++) begin
            rst_in = ($urandom_range(0, 79) == 0);
            rdy_in = ($urandom_range(0, 7) != 0);
            bus.clear_up = ($urandom_range(0, 39) == 0);
            bus.issue_pollute = $urandom_range(0, 1) == 1;
            bus.issue_reg_id = 5'($urandom_range(0, 7));
            bus.issue_rob_entry = RB'($urandom);
            bus.rob_commit = $urandom_range(0, 1) == 1;
            bus.commit_rd_reg_id = 5'($urandom_range(0, 7));
            bus.commit_rob_entry = ($urandom_range(0, 2) != 0) ? m_tag[bus.commit_rd_reg_id] : RB'($urandom);
            bus.commit_value = $urandom;
            bus.rs1_id = 5'($urandom_range(0, 7));
            bus.rs2_id = ($urandom_range(0, 3) == 0) ? bus.rs1_id : 5'($urandom_range(0, 7));
            bus.ready1 = $urandom_range(0, 1) == 1; bus.value1 = $urandom;
            bus.ready2 = $urandom_range(0, 1) == 1; bus.value2 = $urandom;
            #1;
            e1 = exp_read(bus.rs1_id, bus.ready1, bus.value1);
            e2 = exp_read(bus.rs2_id, bus.ready2, bus.value2);
            t1 = m_tag[bus.rs1_id];
            t2 = m_tag[bus.rs2_id];
            n_cmp++;
            if ({bus.rs1_ready, bus.rs1_value, bus.rs1_rob_entry, bus.get_rob_entry1} !== {e1, t1, t1}) begin
                n_fail++;
                $display("FAIL rand_rs1 cyc%0d x%0d: got %b/%h/%h/%h want %b/%h/%h/%h", c, bus.rs1_id, bus.rs1_ready,
                         bus.rs1_value, bus.rs1_rob_entry, bus.get_rob_entry1, e1[32], e1[31:0], t1, t1);
            end
            n_cmp++;
            if ({bus.rs2_ready, bus.rs2_value, bus.rs2_rob_entry, bus.get_rob_entry2} !== {e2, t2, t2}) begin
                n_fail++;
                $display("FAIL rand_rs2 cyc%0d x%0d: got %b/%h/%h/%h want %b/%h/%h/%h", c, bus.rs2_id, bus.rs2_ready,
                         bus.rs2_value, bus.rs2_rob_entry, bus.get_rob_entry2, e2[32], e2[31:0], t2, t2);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        @(negedge clk_in);
        test_reset();
        test_issue_query();
        test_double_issue();
        test_same_cycle();
        test_bypass();
        test_clear();
        test_x0();
        test_random();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
